// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU. Most operations finish in one cycle. MUL is an unsigned
// shift-add multiply that retires one multiplier bit per cycle.
module ula_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ULAOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_SRL, OP_SLL, OP_SLT, OP_AND, OP_MUL, OP_CMP
    } op_t;

    localparam int              CW          = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH[WIDTH-1:0];
    localparam logic [CW-1:0]   LAST_STEP   = CW'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      count_q;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_carry_d;
    logic               alu_ovf_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_d;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        add_ext     = {1'b0, A} + {1'b0, B};
        sub_ext     = {1'b0, A} - {1'b0, B};
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        alu_ovf_d   = 1'b0;
        unique case (op_t'(ULAOp))
            OP_ADD: begin
                alu_res_d   = add_ext[WIDTH-1:0];
                alu_carry_d = add_ext[WIDTH];
                alu_ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res_d[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d   = sub_ext[WIDTH-1:0];
                alu_carry_d = sub_ext[WIDTH];
                alu_ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res_d[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SRL: if (B < SHIFT_LIMIT) alu_res_d = A >> B;
            OP_SLL: if (B < SHIFT_LIMIT) alu_res_d = A << B;
            OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_AND: alu_res_d = A & B;
            OP_MUL: ;
            OP_CMP: alu_res_d = A ^ B;
        endcase

        // Conditionally add the multiplicand into the high half, then shift
        // the whole product right by one. The add's carry-out shifts in at the top.
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            prod_q    <= '0;
            count_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (op_t'(ULAOp) == OP_MUL) begin
                            mcand_q <= A;
                            prod_q  <= {{WIDTH{1'b0}}, B};
                            count_q <= '0;
                            state_q <= S_MUL;
                        end else begin
                            result    <= alu_res_d;
                            result_hi <= '0;
                            zero      <= (alu_res_d == '0);
                            carry     <= alu_carry_d;
                            overflow  <= alu_ovf_d;
                            done      <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    prod_q  <= prod_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        result    <= prod_d[WIDTH-1:0];
                        result_hi <= prod_d[2*WIDTH-1:WIDTH];
                        zero      <= (prod_d == '0);
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
